// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: 4-digit BCD time, run/stop FSM, split display hold, lap FIFO and alarm.
// Define STOPWATCH_COUNT_DOWN_EN to enable count-down mode, preset load, done flag and the DONE state.
module stopwatch_lap_ctrl #(
    parameter int          SEC_H_MAX = 5,
    parameter int          LAP_DEPTH = 4,
    parameter logic [15:0] ALARM_VAL = 16'h1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        split,
    input  logic        lap,
    input  logic        lap_rd,
    input  logic        clear,
    input  logic        mode_down,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] disp,
    output logic        running,
    output logic        held,
    output logic [15:0] lap_data,
    output logic        lap_valid,
    output logic        lap_full,
    output logic        lap_ovf,
    output logic        alarm,
    output logic        done
);

    localparam int          AW       = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam logic [3:0]  SH_MAX   = 4'(SEC_H_MAX);
    localparam logic [15:0] WRAP_VAL = {SH_MAX, 12'h999};
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(LAP_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1'b1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd9) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    r[11:8] = t[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    if (t[15:12] < SH_MAX) begin
                        r[15:12] = t[15:12] + 4'd1;
                    end else begin
                        r[15:12] = 4'd0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Zero is a floor: decrementing 0000 yields 0000 rather than wrapping.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t == 16'h0000) begin
            r = 16'h0000;
        end else if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd9;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_sat(input logic [15:0] t);
        logic [15:0] r;
        r[3:0]   = (t[3:0]   > 4'd9)   ? 4'd9   : t[3:0];
        r[7:4]   = (t[7:4]   > 4'd9)   ? 4'd9   : t[7:4];
        r[11:8]  = (t[11:8]  > 4'd9)   ? 4'd9   : t[11:8];
        r[15:12] = (t[15:12] > SH_MAX) ? SH_MAX : t[15:12];
        return r;
    endfunction

    state_t        state_r, state_next_s;
    logic [15:0]   time_r, time_next_s;
    logic [15:0]   disp_r, disp_next_s;
    logic          held_r, held_next_s;
    logic          alarm_r, alarm_next_s;
    logic          done_r, done_next_s;
    logic          running_r, running_s;

    logic [15:0]   lap_mem_r [LAP_DEPTH];
    logic [AW-1:0] wr_ptr_r, wr_ptr_next_s;
    logic [AW-1:0] rd_ptr_r, rd_ptr_next_s;
    logic [AW:0]   cnt_r, cnt_next_s;
    logic [15:0]   lap_data_r, head_next_s;
    logic          lap_valid_r, lap_valid_s;
    logic          lap_full_r, lap_full_s;
    logic          lap_ovf_r, lap_ovf_next_s;

    logic          active_s, load_ok_s, down_s, ss_s, count_en_s;
    logic          wrap_s, cd_zero_s, full_s, push_s, pop_s, ovf_set_s;
    logic [15:0]   inc_val_s, dec_val_s, load_time_s;

`ifdef STOPWATCH_COUNT_DOWN_EN
    assign load_ok_s   = load && (state_r != ST_RUN);
    assign down_s      = mode_down;
    assign load_time_s = bcd_sat(load_val);
`else
    logic unused_s;
    assign unused_s    = &{1'b0, mode_down, load, load_val};
    assign load_ok_s   = 1'b0;
    assign down_s      = 1'b0;
    assign load_time_s = 16'h0000;
`endif

    // Load outranks start_stop, which in turn suppresses a coincident tick.
    assign active_s   = (state_r == ST_RUN) || (state_r == ST_STOP);
    assign ss_s       = start_stop && !load_ok_s;
    assign count_en_s = (state_r == ST_RUN) && tick && !ss_s;
    assign inc_val_s  = bcd_inc(time_r);
    assign dec_val_s  = bcd_dec(time_r);
    assign wrap_s     = (time_r == WRAP_VAL);
    assign cd_zero_s  = count_en_s && down_s && (dec_val_s == 16'h0000);

    // FIFO handshake: a pop frees the slot a same-edge push needs when full.
    assign full_s    = (cnt_r == DEPTH_C);
    assign pop_s     = lap_rd && (cnt_r != {(AW + 1){1'b0}});
    assign push_s    = lap && active_s && (!full_s || pop_s);
    assign ovf_set_s = lap && active_s && full_s && !pop_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        if (clear) begin
            state_next_s = ST_IDLE;
        end else if (load_ok_s) begin
            state_next_s = (state_r == ST_DONE) ? ST_STOP : state_r;
        end else begin
            case (state_r)
                ST_IDLE: state_next_s = ss_s ? ST_RUN : ST_IDLE;
                ST_RUN: begin
                    if (ss_s) begin
                        state_next_s = ST_STOP;
                    end else if (cd_zero_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_STOP: state_next_s = ss_s ? ST_RUN : ST_STOP;
                ST_DONE: state_next_s = ST_DONE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // FSM-derived outputs, taken from the next state so they register in step with it.
    always_comb begin
        running_s = (state_next_s == ST_RUN);
    end

    // Time, alarm and done next values.
    always_comb begin
        time_next_s  = time_r;
        alarm_next_s = alarm_r;
        done_next_s  = done_r;
        if (clear) begin
            time_next_s  = 16'h0000;
            alarm_next_s = 1'b0;
            done_next_s  = 1'b0;
        end else if (load_ok_s) begin
            time_next_s = load_time_s;
            done_next_s = 1'b0;
        end else if (count_en_s && down_s) begin
            time_next_s = dec_val_s;
            done_next_s = cd_zero_s ? 1'b1 : done_r;
        end else if (count_en_s) begin
            time_next_s = inc_val_s;
            if (wrap_s) begin
                alarm_next_s = 1'b0;
            end else if (inc_val_s == ALARM_VAL) begin
                alarm_next_s = 1'b1;
            end else begin
                alarm_next_s = alarm_r;
            end
        end else begin
            time_next_s = time_r;
        end
    end

    // Split hold and display: an unheld display tracks the time register's next value.
    always_comb begin
        held_next_s = held_r;
        disp_next_s = disp_r;
        if (clear) begin
            held_next_s = 1'b0;
        end else if (split && active_s) begin
            held_next_s = ~held_r;
        end else begin
            held_next_s = held_r;
        end
        if (clear) begin
            disp_next_s = 16'h0000;
        end else if (held_next_s) begin
            disp_next_s = disp_r;
        end else begin
            disp_next_s = time_next_s;
        end
    end

    // FIFO pointers, occupancy and show-ahead head value.
    always_comb begin
        wr_ptr_next_s  = wr_ptr_r;
        rd_ptr_next_s  = rd_ptr_r;
        cnt_next_s     = cnt_r;
        head_next_s    = lap_data_r;
        lap_ovf_next_s = lap_ovf_r;
        if (clear) begin
            wr_ptr_next_s  = {AW{1'b0}};
            rd_ptr_next_s  = {AW{1'b0}};
            cnt_next_s     = {(AW + 1){1'b0}};
            head_next_s    = 16'h0000;
            lap_ovf_next_s = 1'b0;
        end else begin
            wr_ptr_next_s  = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_next_s  = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            lap_ovf_next_s = lap_ovf_r || ovf_set_s;
            case ({push_s, pop_s})
                2'b10:   cnt_next_s = cnt_r + CNT_ONE;
                2'b01:   cnt_next_s = cnt_r - CNT_ONE;
                default: cnt_next_s = cnt_r;
            endcase
            // The new head may be the slot written on this very edge.
            if (cnt_next_s == {(AW + 1){1'b0}}) begin
                head_next_s = lap_data_r;
            end else if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
                head_next_s = time_r;
            end else begin
                head_next_s = lap_mem_r[rd_ptr_next_s];
            end
        end
        lap_valid_s = (cnt_next_s != {(AW + 1){1'b0}});
        lap_full_s  = (cnt_next_s == DEPTH_C);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_r      <= 16'h0000;
            disp_r      <= 16'h0000;
            held_r      <= 1'b0;
            alarm_r     <= 1'b0;
            done_r      <= 1'b0;
            running_r   <= 1'b0;
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            cnt_r       <= {(AW + 1){1'b0}};
            lap_data_r  <= 16'h0000;
            lap_valid_r <= 1'b0;
            lap_full_r  <= 1'b0;
            lap_ovf_r   <= 1'b0;
        end else begin
            time_r      <= time_next_s;
            disp_r      <= disp_next_s;
            held_r      <= held_next_s;
            alarm_r     <= alarm_next_s;
            done_r      <= done_next_s;
            running_r   <= running_s;
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            cnt_r       <= cnt_next_s;
            lap_data_r  <= head_next_s;
            lap_valid_r <= lap_valid_s;
            lap_full_r  <= lap_full_s;
            lap_ovf_r   <= lap_ovf_next_s;
        end
    end

    // Lap storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_mem_r[i] <= 16'h0000;
            end
        end else if (!clear && push_s) begin
            lap_mem_r[wr_ptr_r] <= time_r;
        end
    end

    assign disp      = disp_r;
    assign running   = running_r;
    assign held      = held_r;
    assign lap_data  = lap_data_r;
    assign lap_valid = lap_valid_r;
    assign lap_full  = lap_full_r;
    assign lap_ovf   = lap_ovf_r;
    assign alarm     = alarm_r;
    assign done      = done_r;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Bench for stopwatch_lap_ctrl: integer-centisecond model with a lap queue, checked every cycle,
// plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_stopwatch_lap_ctrl;

    localparam int          SEC_H_MAX = 5;
    localparam int          LAP_DEPTH = 4;
    localparam logic [15:0] ALARM_VAL = 16'h1000;
    localparam int          MAX_CS    = SEC_H_MAX * 1000 + 999;
    localparam int          S_IDLE = 0, S_RUN = 1, S_STOP = 2, S_DONE = 3;

    logic clk = 1'b0;
    logic rst, tick, start_stop, split, lap, lap_rd, clear, mode_down, load;
    logic [15:0] load_val;
    logic [15:0] disp, lap_data;
    logic running, held, lap_valid, lap_full, lap_ovf, alarm, done;

    always #5 clk = ~clk;

    stopwatch_lap_ctrl #(
        .SEC_H_MAX(SEC_H_MAX),
        .LAP_DEPTH(LAP_DEPTH),
        .ALARM_VAL(ALARM_VAL)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .split(split),
        .lap(lap), .lap_rd(lap_rd), .clear(clear), .mode_down(mode_down), .load(load),
        .load_val(load_val), .disp(disp), .running(running), .held(held),
        .lap_data(lap_data), .lap_valid(lap_valid), .lap_full(lap_full),
        .lap_ovf(lap_ovf), .alarm(alarm), .done(done)
    );

    int n_cmp = 0;
    int n_err = 0;

    int          m_t;
    int          m_st;
    bit          m_held, m_alarm, m_done, m_ovf;
    logic [15:0] m_disp, m_lap_last;
    logic [15:0] m_q[$];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] sat_bcd(input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  d;
        int          lim;
        for (int i = 0; i < 4; i++) begin
            d   = b[4*i +: 4];
            lim = (i == 3) ? SEC_H_MAX : 9;
            if (int'(d) > lim) d = 4'(lim);
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_st = S_IDLE; m_held = 1'b0; m_alarm = 1'b0; m_done = 1'b0;
        m_ovf = 1'b0; m_disp = 16'h0000; m_lap_last = 16'h0000;
        m_q.delete();
    endtask

    // Applies one clock edge of the behavioural rules to the model.
    task automatic model_step();
        int  st;
        bit  load_ok;
        st = m_st;
        if (clear) begin
            model_reset();
            return;
        end
`ifdef STOPWATCH_COUNT_DOWN_EN
        load_ok = load && (st != S_RUN);
`else
        load_ok = 1'b0;
`endif
        if (lap_rd && m_q.size() > 0) void'(m_q.pop_front());
        if (lap && (st == S_RUN || st == S_STOP)) begin
            if (m_q.size() < LAP_DEPTH) m_q.push_back(to_bcd(m_t));
            else m_ovf = 1'b1;
        end
        if (m_q.size() > 0) m_lap_last = m_q[0];
        if (split && (st == S_RUN || st == S_STOP)) m_held = !m_held;
        if (load_ok) begin
            m_t = from_bcd(sat_bcd(load_val));
            m_done = 1'b0;
            if (st == S_DONE) m_st = S_STOP;
        end else if (start_stop) begin
            if (st == S_IDLE || st == S_STOP) m_st = S_RUN;
            else if (st == S_RUN) m_st = S_STOP;
        end else if (st == S_RUN && tick) begin
`ifdef STOPWATCH_COUNT_DOWN_EN
            if (mode_down) begin
                if (m_t > 0) m_t = m_t - 1;
                if (m_t == 0) begin
                    m_done = 1'b1;
                    m_st = S_DONE;
                end
            end else
`endif
            if (m_t == MAX_CS) begin
                m_t = 0;
                m_alarm = 1'b0;
            end else begin
                m_t = m_t + 1;
                if (to_bcd(m_t) == ALARM_VAL) m_alarm = 1'b1;
            end
        end
        if (!m_held) m_disp = to_bcd(m_t);
    endtask

    task automatic compare_all();
        check("disp", disp, m_disp);
        check("running", 16'(running), 16'(m_st == S_RUN));
        check("held", 16'(held), 16'(m_held));
        check("lap_data", lap_data, m_lap_last);
        check("lap_valid", 16'(lap_valid), 16'(m_q.size() > 0));
        check("lap_full", 16'(lap_full), 16'(m_q.size() == LAP_DEPTH));
        check("lap_ovf", 16'(lap_ovf), 16'(m_ovf));
        check("alarm", 16'(alarm), 16'(m_alarm));
        check("done", 16'(done), 16'(m_done));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        compare_all();
        tick = 1'b0; start_stop = 1'b0; split = 1'b0; lap = 1'b0;
        lap_rd = 1'b0; clear = 1'b0; load = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc();
            cyc();
        end
    endtask

    logic [15:0] exp_rd [4];

    initial begin
        rst = 1'b1; tick = 1'b0; start_stop = 1'b0; split = 1'b0; lap = 1'b0;
        lap_rd = 1'b0; clear = 1'b0; mode_down = 1'b0; load = 1'b0; load_val = 16'h0000;
        model_reset();
        @(negedge clk);
        compare_all();
        check("rst_disp", disp, 16'h0000);
        check("rst_lap_valid", 16'(lap_valid), 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Idle: ticks, split, lap and empty pop have no effect.
        tick_n(3);
        split = 1'b1; cyc();
        lap = 1'b1; cyc();
        lap_rd = 1'b1; cyc();
        check("idle_held", 16'(held), 16'h0000);
        check("idle_lap_valid", 16'(lap_valid), 16'h0000);

        // Count to the alarm point, then to the wrap.
        start_stop = 1'b1; cyc();
        tick_n(999);
        check("pre_alarm", 16'(alarm), 16'h0000);
        tick_n(1);
        check("alarm_disp", disp, 16'h1000);
        check("alarm_set", 16'(alarm), 16'h0001);
        check("alarm_running", 16'(running), 16'h0001);
        tick_n(4999);
        check("max_disp", disp, 16'h5999);
        tick_n(1);
        check("wrap_disp", disp, 16'h0000);
        check("wrap_alarm", 16'(alarm), 16'h0000);

        // Stop freezes time; load is only honoured with count-down support.
        start_stop = 1'b1; cyc();
        tick_n(5);
        check("stop_running", 16'(running), 16'h0000);
        mode_down = 1'b1; load_val = 16'h1234; load = 1'b1; cyc();
        mode_down = 1'b0;
        clear = 1'b1; cyc();

        // Split hold and release.
        start_stop = 1'b1; cyc();
        tick_n(37);
        split = 1'b1; cyc();
        check("split_held", 16'(held), 16'h0001);
        tick_n(50);
        check("split_frozen", disp, 16'h0037);
        split = 1'b1; cyc();
        check("split_release", disp, 16'h0087);
        check("split_unheld", 16'(held), 16'h0000);

        // Five laps into a four-deep FIFO, then drain.
        clear = 1'b1; cyc();
        start_stop = 1'b1; cyc();
        for (int i = 0; i < 5; i++) begin
            tick_n(1);
            lap = 1'b1; cyc();
        end
        check("ovf_full", 16'(lap_full), 16'h0001);
        check("ovf_flag", 16'(lap_ovf), 16'h0001);
        exp_rd = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        for (int i = 0; i < 4; i++) begin
            check("drain_head", lap_data, exp_rd[i]);
            lap_rd = 1'b1; cyc();
        end
        check("drain_empty", 16'(lap_valid), 16'h0000);
        check("drain_hold", lap_data, 16'h0004);

        // Simultaneous push and pop while full.
        clear = 1'b1; cyc();
        start_stop = 1'b1; cyc();
        for (int i = 0; i < 4; i++) begin
            tick_n(1);
            lap = 1'b1; cyc();
        end
        tick_n(1);
        lap = 1'b1; lap_rd = 1'b1; cyc();
        check("pp_full", 16'(lap_full), 16'h0001);
        check("pp_ovf", 16'(lap_ovf), 16'h0000);
        exp_rd = '{16'h0002, 16'h0003, 16'h0004, 16'h0005};
        for (int i = 0; i < 4; i++) begin
            check("pp_head", lap_data, exp_rd[i]);
            lap_rd = 1'b1; cyc();
        end
        check("pp_empty", 16'(lap_valid), 16'h0000);

        // Asynchronous reset mid-run with a lap pending.
        lap = 1'b1; cyc();
        lap = 1'b1; rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("arst_running", 16'(running), 16'h0000);
        cyc();
        rst = 1'b0;
        cyc();
        check("arst_lap_valid", 16'(lap_valid), 16'h0000);

`ifdef STOPWATCH_COUNT_DOWN_EN
        mode_down = 1'b1;
        load_val = 16'h0003; load = 1'b1; cyc();
        check("cd_load", disp, 16'h0003);
        start_stop = 1'b1; cyc();
        tick_n(3);
        check("cd_zero", disp, 16'h0000);
        check("cd_done", 16'(done), 16'h0001);
        check("cd_not_running", 16'(running), 16'h0000);
        start_stop = 1'b1; cyc();
        check("cd_ss_ignored", 16'(running), 16'h0000);
        load_val = 16'h0100; load = 1'b1; cyc();
        check("cd_reload_done", 16'(done), 16'h0000);
        check("cd_reload_disp", disp, 16'h0100);
        start_stop = 1'b1; cyc();
        check("cd_restart", 16'(running), 16'h0001);
        tick_n(1);
        check("cd_borrow", disp, 16'h0099);
        start_stop = 1'b1; cyc();
        load_val = 16'hFAFA; load = 1'b1; cyc();
        check("cd_saturate", disp, 16'h5999);
        mode_down = 1'b0;
        clear = 1'b1; cyc();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
